// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and constants for the TPU v2 control front-end.
//   state_t        - compute sequencer states
//   DEF_*          - default register/region map
//   STAT_* / CMD_* - bit positions inside the status and command words
//   max1()         - clamps an index width to at least one bit
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [15:0] DEF_BASE_A    = 16'h0100;
  localparam logic [15:0] DEF_BASE_B    = 16'h0200;
  localparam logic [15:0] DEF_BASE_C    = 16'h0300;
  localparam logic [15:0] DEF_CMD_ADDR  = 16'h0400;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0408;
  // Performance counter sits at this offset from the command register.
  localparam logic [15:0] PERF_OFFSET   = 16'h0010;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CMD_START = 0;
  localparam int CMD_ACC   = 1;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/tpu_addr_dec.sv
// tpu_addr_dec: purely combinational decode of the host byte address.
//   addr      in   host byte address
//   hit_a/b/c out  address falls inside the A, B or C row region
//   hit_cmd   out  address equals the command register
//   hit_stat  out  address equals the status register
//   a_row     out  A row index (offset / A row stride)
//   c_row     out  C row index (offset / C row stride)
//   c_word    out  host word within the addressed C row
// Indices are produced for any address; they are only meaningful when the
// matching region hit is asserted. Low offset bits below a row/word stride
// are dropped by the divisions.
module tpu_addr_dec
  import tpu_pkg::*;
#(
  parameter int                DIM       = 8,
  parameter int                BITS_C    = 16,
  parameter int                ADDRW     = 16,
  parameter int                DATAW     = 64,
  parameter int                RW        = 3,
  parameter int                CW        = 1,
  parameter logic [ADDRW-1:0]  BASE_A    = ADDRW'(DEF_BASE_A),
  parameter logic [ADDRW-1:0]  BASE_B    = ADDRW'(DEF_BASE_B),
  parameter logic [ADDRW-1:0]  BASE_C    = ADDRW'(DEF_BASE_C),
  parameter logic [ADDRW-1:0]  CMD_ADDR  = ADDRW'(DEF_CMD_ADDR),
  parameter logic [ADDRW-1:0]  STAT_ADDR = ADDRW'(DEF_STAT_ADDR)
) (
  input  logic [ADDRW-1:0] addr,
  output logic             hit_a,
  output logic             hit_b,
  output logic             hit_c,
  output logic             hit_cmd,
  output logic             hit_stat,
  output logic [RW-1:0]    a_row,
  output logic [RW-1:0]    c_row,
  output logic [CW-1:0]    c_word
);

  localparam logic [ADDRW-1:0] AB_STRIDE = ADDRW'(DATAW / 8);
  localparam logic [ADDRW-1:0] C_STRIDE  = ADDRW'(DIM * BITS_C / 8);
  localparam logic [ADDRW-1:0] AB_SIZE   = ADDRW'(DIM * DATAW / 8);
  localparam logic [ADDRW-1:0] C_SIZE    = ADDRW'(DIM * DIM * BITS_C / 8);

  logic [ADDRW-1:0] a_off, b_off, c_off;
  logic [ADDRW-1:0] a_idx, c_idx, c_widx;
  logic             unused_idx_bits;

  // Offsets wrap to large values below the base, so one unsigned compare
  // covers both ends of each region.
  assign a_off = addr - BASE_A;
  assign b_off = addr - BASE_B;
  assign c_off = addr - BASE_C;

  assign hit_a    = (a_off < AB_SIZE);
  assign hit_b    = (b_off < AB_SIZE);
  assign hit_c    = (c_off < C_SIZE);
  assign hit_cmd  = (addr == CMD_ADDR);
  assign hit_stat = (addr == STAT_ADDR);

  assign a_idx  = a_off / AB_STRIDE;
  assign c_idx  = c_off / C_STRIDE;
  assign c_widx = (c_off % C_STRIDE) / AB_STRIDE;

  assign a_row  = a_idx[RW-1:0];
  assign c_row  = c_idx[RW-1:0];
  assign c_word = c_widx[CW-1:0];

  assign unused_idx_bits = ^{a_idx[ADDRW-1:RW], c_idx[ADDRW-1:RW], c_widx[ADDRW-1:CW]};

endmodule

// File: rtl/tpuv2_ctrl.sv
// tpuv2_ctrl: memory-mapped control front-end for the systolic matmul engine.
//   clk, rst        clock, asynchronous active-high reset
//   r_w/addr/dataIn host access (1 = write), decoded every cycle
//   dataOut         registered read data (1-cycle latency)
//   c_row_data      selected C row from the array, element 0 in LSBs
//   a_wr_en/a_row   A row write strobe and index
//   b_en            B shift strobe
//   c_wr_en/c_row/c_word  C word write strobe and location
//   c_clr           one-cycle clear of all C accumulators
//   sys_en          advance array / A feed one step
//   busy, done      compute in progress / sticky run complete
// Optional build macro TPU_PERF_CNT_EN adds a saturating 32-bit busy-cycle
// counter readable at CMD_ADDR+0x10 (reads 0 when the macro is undefined).
module tpuv2_ctrl
  import tpu_pkg::*;
#(
  parameter int                BITS_AB   = 8,
  parameter int                BITS_C    = 16,
  parameter int                DIM       = 8,
  parameter int                ADDRW     = 16,
  parameter int                DATAW     = 64,
  parameter logic [ADDRW-1:0]  BASE_A    = ADDRW'(DEF_BASE_A),
  parameter logic [ADDRW-1:0]  BASE_B    = ADDRW'(DEF_BASE_B),
  parameter logic [ADDRW-1:0]  BASE_C    = ADDRW'(DEF_BASE_C),
  parameter logic [ADDRW-1:0]  CMD_ADDR  = ADDRW'(DEF_CMD_ADDR),
  parameter logic [ADDRW-1:0]  STAT_ADDR = ADDRW'(DEF_STAT_ADDR)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       r_w,
  input  logic [ADDRW-1:0]                           addr,
  input  logic [DATAW-1:0]                           dataIn,
  output logic [DATAW-1:0]                           dataOut,
  input  logic [DIM*BITS_C-1:0]                      c_row_data,
  output logic                                       a_wr_en,
  output logic [$clog2(DIM)-1:0]                     a_row,
  output logic                                       b_en,
  output logic                                       c_wr_en,
  output logic [$clog2(DIM)-1:0]                     c_row,
  output logic [max1($clog2(DIM*BITS_C/DATAW))-1:0]  c_word,
  output logic                                       c_clr,
  output logic                                       sys_en,
  output logic                                       busy,
  output logic                                       done
);

  localparam int WORDS   = DIM * BITS_C / DATAW;
  localparam int RW      = $clog2(DIM);
  localparam int CW      = max1($clog2(WORDS));
  localparam int RUN_LEN = 3 * DIM - 2;
  localparam int CNTW    = $clog2(3 * DIM - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(RUN_LEN - 1);

  logic hit_a, hit_b, hit_c, hit_cmd, hit_stat, hit_perf;
  logic idle, start_req, start_acc, err_set, err_clr;
  logic unused_data_bits;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATAW-1:0]  dataout_q, dataout_d;

  logic [DATAW-1:0]  c_words [WORDS];
  logic [DATAW-1:0]  c_sel;
  logic [DATAW-1:0]  stat_word;
  logic [DATAW-1:0]  perf_rd;

  tpu_addr_dec #(
    .DIM(DIM), .BITS_C(BITS_C), .ADDRW(ADDRW), .DATAW(DATAW), .RW(RW), .CW(CW),
    .BASE_A(BASE_A), .BASE_B(BASE_B), .BASE_C(BASE_C),
    .CMD_ADDR(CMD_ADDR), .STAT_ADDR(STAT_ADDR)
  ) u_dec (
    .addr(addr), .hit_a(hit_a), .hit_b(hit_b), .hit_c(hit_c),
    .hit_cmd(hit_cmd), .hit_stat(hit_stat),
    .a_row(a_row), .c_row(c_row), .c_word(c_word)
  );

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_cword
    assign c_words[gi] = c_row_data[gi*DATAW +: DATAW];
  end
  assign c_sel = c_words[c_word];

  assign idle      = (state_q == IDLE);
  assign busy      = ~idle;
  assign done      = done_q;
  assign dataOut   = dataout_q;

  assign start_req = hit_cmd & r_w & dataIn[CMD_START];
  assign start_acc = start_req & idle;

  // Bus strobes are only honoured while idle; in a run they flag an error.
  assign a_wr_en = idle & r_w & hit_a;
  assign b_en    = idle & r_w & hit_b;
  assign c_wr_en = idle & r_w & hit_c;

  assign err_set = busy & ((r_w & (hit_a | hit_b | hit_c)) | start_req | (~r_w & hit_c));
  assign err_clr = hit_stat & r_w & dataIn[STAT_ERR];

  assign unused_data_bits = ^dataIn[DATAW-1:3];

  always_comb begin
    stat_word            = '0;
    stat_word[STAT_BUSY] = busy;
    stat_word[STAT_DONE] = done_q;
    stat_word[STAT_ERR]  = err_q;
  end

`ifdef TPU_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  assign hit_perf = (addr == CMD_ADDR + ADDRW'(PERF_OFFSET));
  assign perf_rd  = DATAW'(perf_q);

  always_comb begin
    perf_d = perf_q;
    if (start_acc)
      perf_d = '0;
    else if (busy && (perf_q != '1))
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end
`else
  assign hit_perf = 1'b0;
  assign perf_rd  = '0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = done_q;
    err_d     = err_q;
    dataout_d = '0;
    c_clr     = 1'b0;
    sys_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          done_d  = 1'b0;
          count_d = '0;
          state_d = dataIn[CMD_ACC] ? RUN : CLEAR;
        end
      end
      CLEAR: begin
        c_clr   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        sys_en  = 1'b1;
        count_d = count_q + 1'b1;
        // count_q holds the number of sys_en cycles already issued.
        if (count_q == LAST_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over the write-one-to-clear.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    if (!r_w) begin
      if (hit_c)         dataout_d = busy ? '0 : c_sel;
      else if (hit_stat) dataout_d = stat_word;
      else if (hit_perf) dataout_d = perf_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dataout_q <= dataout_d;
    end
  end

endmodule

// File: tb/tb_tpuv2_ctrl.sv
// tb_tpuv2_ctrl: directed plus randomized stimulus for tpuv2_ctrl with a
// run-length style reference model (remaining-cycle counter, sticky flags).
module tb_tpuv2_ctrl;

  localparam int RUN_LEN = 22;
  localparam logic [15:0] CMD  = 16'h0400;
  localparam logic [15:0] STAT = 16'h0408;
  localparam logic [15:0] PERF = 16'h0410;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_w = 1'b0;
  logic [15:0]   addr = '0;
  logic [63:0]   dataIn = '0;
  logic [63:0]   dataOut;
  logic [127:0]  c_row_data = '0;
  logic          a_wr_en, b_en, c_wr_en, c_clr, sys_en, busy, done;
  logic [2:0]    a_row, c_row;
  logic [0:0]    c_word;

  tpuv2_ctrl dut (
    .clk(clk), .rst(rst), .r_w(r_w), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .c_row_data(c_row_data),
    .a_wr_en(a_wr_en), .a_row(a_row), .b_en(b_en), .c_wr_en(c_wr_en),
    .c_row(c_row), .c_word(c_word), .c_clr(c_clr), .sys_en(sys_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending clear pulse plus a count of sys_en cycles left.
  bit          m_clr  = 1'b0;
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_perf = '0;
  int          n_sys  = 0;
  int          n_clr  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_a(input logic [15:0] a);
    return (a >= 16'h0100) && (a < 16'h0140);
  endfunction
  function automatic bit in_b(input logic [15:0] a);
    return (a >= 16'h0200) && (a < 16'h0240);
  endfunction
  function automatic bit in_c(input logic [15:0] a);
    return (a >= 16'h0300) && (a < 16'h0380);
  endfunction

  function automatic bit m_busy();
    return m_clr || (m_left > 0);
  endfunction

  task automatic model_reset();
    m_clr = 1'b0; m_left = 0; m_done = 1'b0; m_err = 1'b0; m_perf = '0;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, step the
  // model at the posedge, then check registered outputs.
  task automatic cycle(input logic rw, input logic [15:0] ad, input logic [63:0] din,
                       input logic [127:0] cd);
    bit          bsy, start, eset, eclr;
    logic [63:0] exp_dout;
    int          off, w;
    @(negedge clk);
    r_w = rw; addr = ad; dataIn = din; c_row_data = cd;
    #1;
    bsy = m_busy();
    check("a_wr_en", 64'(a_wr_en), 64'(!bsy && rw && in_a(ad)));
    check("b_en",    64'(b_en),    64'(!bsy && rw && in_b(ad)));
    check("c_wr_en", 64'(c_wr_en), 64'(!bsy && rw && in_c(ad)));
    check("c_clr",   64'(c_clr),   64'(m_clr));
    check("sys_en",  64'(sys_en),  64'(!m_clr && m_left > 0));
    check("busy",    64'(busy),    64'(bsy));
    check("done",    64'(done),    64'(m_done));
    if (in_a(ad)) check("a_row", 64'(a_row), 64'(((int'(ad) - 'h100) / 8) % 8));
    off = int'(ad) - 'h300;
    w   = (off % 16) / 8;
    if (in_c(ad)) begin
      check("c_row",  64'(c_row),  64'((off / 16) % 8));
      check("c_word", 64'(c_word), 64'(w));
    end
    if (sys_en) n_sys++;
    if (c_clr)  n_clr++;

    start    = rw && (ad == CMD) && din[0];
    exp_dout = '0;
    if (!rw) begin
      if (in_c(ad))        exp_dout = bsy ? 64'h0 : cd[w*64 +: 64];
      else if (ad == STAT) exp_dout = {61'h0, m_err, m_done, bsy};
`ifdef TPU_PERF_CNT_EN
      else if (ad == PERF) exp_dout = {32'h0, m_perf};
`endif
    end
    eset = bsy && ((rw && (in_a(ad) || in_b(ad) || in_c(ad))) || start || (!rw && in_c(ad)));
    eclr = rw && (ad == STAT) && din[2];

    if (!bsy && start)                         m_perf = '0;
    else if (bsy && m_perf != 32'hFFFF_FFFF)   m_perf = m_perf + 32'd1;
    if (eset)      m_err = 1'b1;
    else if (eclr) m_err = 1'b0;
    if (m_clr) m_clr = 1'b0;
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (start) begin
      m_done = 1'b0;
      m_left = RUN_LEN;
      m_clr  = !din[1];
    end

    @(posedge clk);
    #1;
    if (!rw) check("dataOut", dataOut, exp_dout);
    check("busy_q", 64'(busy), 64'(m_busy()));
    check("done_q", 64'(done), 64'(m_done));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 64'h0, 128'h0);
  endtask

  logic [127:0] cdat;
  logic [15:0]  raddr;
  logic [63:0]  rdata;
  int           sel;

  initial begin
    // Reset state
    #12;
    check("rst_dataOut", dataOut, 64'h0);
    check("rst_busy",    64'(busy), 64'h0);
    check("rst_done",    64'(done), 64'h0);
    check("rst_sys_en",  64'(sys_en), 64'h0);
    check("rst_c_clr",   64'(c_clr), 64'h0);
    check("rst_strobes", 64'({a_wr_en, b_en, c_wr_en}), 64'h0);
    @(negedge clk); rst = 1'b0;

    // A write then A read
    cycle(1'b1, 16'h0108, 64'h0807060504030201, 128'h0);
    check("tp_a_wr_en", 64'(a_wr_en), 64'h1);
    check("tp_a_row",   64'(a_row),   64'h1);
    cycle(1'b0, 16'h0108, 64'h0, 128'h0);
    check("tp_a_read", dataOut, 64'h0);

    // Clearing run
    n_sys = 0; n_clr = 0;
    cycle(1'b1, CMD, 64'h1, 128'h0);
    idle_cycles(26);
    check("tp_run_sys_cnt", 64'(n_sys), 64'd22);
    check("tp_run_clr_cnt", 64'(n_clr), 64'd1);
    cycle(1'b0, STAT, 64'h0, 128'h0);
    check("tp_stat_done", dataOut, 64'h2);
`ifdef TPU_PERF_CNT_EN
    cycle(1'b0, PERF, 64'h0, 128'h0);
    check("tp_perf_clear_run", dataOut, 64'd23);
`endif

    // Accumulate run: no clear pulse, sys_en right after the command
    n_sys = 0; n_clr = 0;
    cycle(1'b1, CMD, 64'h3, 128'h0);
    check("tp_acc_sys_en_next", 64'(sys_en), 64'h1);
    check("tp_acc_no_clr",      64'(c_clr),  64'h0);
    idle_cycles(25);
    check("tp_acc_sys_cnt", 64'(n_sys), 64'd22);
    check("tp_acc_clr_cnt", 64'(n_clr), 64'd0);

    // Errors during a run
    cycle(1'b1, CMD, 64'h1, 128'h0);
    idle_cycles(3);
    cycle(1'b1, 16'h0200, 64'h55, 128'h0);
    cycle(1'b1, CMD, 64'h1, 128'h0);
    cycle(1'b0, 16'h0310, 64'h0, {4{32'hCAFE_F00D}});
    check("tp_busy_c_read", dataOut, 64'h0);
    cycle(1'b0, STAT, 64'h0, 128'h0);
    check("tp_stat_err_busy", dataOut, 64'h5);
    idle_cycles(24);
    cycle(1'b1, STAT, 64'h4, 128'h0);
    cycle(1'b0, STAT, 64'h0, 128'h0);
    check("tp_stat_err_cleared", dataOut, 64'h2);

    // C word select
    cdat = {64'hDEAD_BEEF_0000_0001, 64'h1111_2222_3333_4444};
    cycle(1'b0, 16'h0318, 64'h0, cdat);
    check("tp_c_row",  64'(c_row),  64'h1);
    check("tp_c_word", 64'(c_word), 64'h1);
    check("tp_c_data", dataOut, 64'hDEAD_BEEF_0000_0001);

    // Reset at RUN cycle 10
    n_sys = 0;
    cycle(1'b1, CMD, 64'h1, 128'h0);
    idle_cycles(11);
    check("tp_pre_rst_sys", 64'(n_sys), 64'd10);
    @(negedge clk); rst = 1'b1;
    #1;
    check("tp_rst_busy",   64'(busy),   64'h0);
    check("tp_rst_sys_en", 64'(sys_en), 64'h0);
    check("tp_rst_done",   64'(done),   64'h0);
    check("tp_rst_c_clr",  64'(c_clr),  64'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    n_sys = 0; n_clr = 0;
    cycle(1'b1, CMD, 64'h1, 128'h0);
    idle_cycles(26);
    check("tp_post_rst_sys", 64'(n_sys), 64'd22);
    check("tp_post_rst_clr", 64'(n_clr), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: raddr = 16'h0100 + 16'($urandom_range(0, 63));
        1: raddr = 16'h0200 + 16'($urandom_range(0, 63));
        2: raddr = 16'h0300 + 16'($urandom_range(0, 127));
        3: raddr = CMD;
        4: raddr = STAT;
        5: raddr = PERF;
        default: raddr = 16'($urandom);
      endcase
      rdata = {$urandom, $urandom};
      cdat  = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), raddr, rdata, cdat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
